// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED 4-wire serial link.
package oled_pkg;

  localparam int unsigned BYTE_W = 8;

  // Command opcode bases recognised by the panel.
  localparam logic [7:0] CMD_PAGE_BASE   = 8'hB0;
  localparam logic [7:0] CMD_COL_LO_BASE = 8'h00;
  localparam logic [7:0] CMD_COL_HI_BASE = 8'h10;

  // Default GRAM geometry: 8 pages by 128 columns.
  localparam int unsigned PAGE_W = 3;
  localparam int unsigned COL_W  = 7;

  // Serial word as framed by the master: DC flag alongside the byte, MSB first.
  localparam int unsigned SPI_WORD_W = BYTE_W + 1;
  localparam int unsigned SPI_DC_BIT = BYTE_W;

  typedef struct packed {
    logic             dc;
    logic [BYTE_W-1:0] data;
  } spi_word_t;

  typedef enum logic [1:0] {
    CMD_NONE   = 2'd0,
    CMD_PAGE   = 2'd1,
    CMD_COL_LO = 2'd2,
    CMD_COL_HI = 2'd3
  } cmd_kind_e;

  // Classify a command byte into the pointer field it updates.
  function automatic cmd_kind_e classify_cmd(input logic [7:0] b);
    cmd_kind_e kind;
    kind = CMD_NONE;
    if (b[7:3] == CMD_PAGE_BASE[7:3]) begin
      kind = CMD_PAGE;
    end else if (b[7:4] == CMD_COL_LO_BASE[7:4]) begin
      kind = CMD_COL_LO;
    end else if (b[7:3] == CMD_COL_HI_BASE[7:3]) begin
      kind = CMD_COL_HI;
    end
    return kind;
  endfunction

endpackage

// File: rtl/oled_spi_deser.sv
// Serial deserializer: input synchronizers, SCLK rise detect, shift/count, framing error.
module oled_spi_deser
  import oled_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      sclk,
  input  logic      cs_n,
  input  logic      dc,
  input  logic      din,
  output logic      rx_valid,
  output spi_word_t rx_word,
  output logic      frame_err,
  output logic      done_c,
  output spi_word_t word_c
);

  localparam int unsigned SYNC_W = SYNC_STAGES * 4;
  // Sync lane order {sclk, cs_n, dc, din}; CS idles deasserted out of reset.
  localparam logic [3:0] SYNC_IDLE = 4'b0100;

  logic [SYNC_W-1:0] sync_q, sync_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic              cs_prev_q, cs_prev_d;
  logic [6:0]        shift_q, shift_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  spi_word_t         word_q, word_d;
  logic              ferr_q, ferr_d;

  logic [3:0] sync_top_c;
  logic       sclk_s_c, cs_s_c, dc_s_c, din_s_c;
  logic       sclk_rise_c, cs_rise_c, bit_en_c;

  assign sync_top_c = sync_q[SYNC_W-1 -: 4];
  assign sclk_s_c   = sync_top_c[3];
  assign cs_s_c     = sync_top_c[2];
  assign dc_s_c     = sync_top_c[1];
  assign din_s_c    = sync_top_c[0];

  assign sclk_rise_c = sclk_s_c & ~sclk_prev_q;
  assign cs_rise_c   = cs_s_c & ~cs_prev_q;
  // Gate on the previous CS sample so an 8th rise coincident with CS rise still lands.
  assign bit_en_c    = sclk_rise_c & ~cs_prev_q;

  // Next-state: synchronizers, shift/count, byte completion and framing error.
  always_comb begin
    sync_d      = {sync_q[SYNC_W-5:0], sclk, cs_n, dc, din};
    sclk_prev_d = sclk_s_c;
    cs_prev_d   = cs_s_c;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    word_d      = word_q;
    ferr_d      = 1'b0;
    done_c      = 1'b0;
    word_c      = '{dc: dc_s_c, data: {shift_q, din_s_c}};

    if (bit_en_c) begin
      shift_d = {shift_q[5:0], din_s_c};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        done_c = 1'b1;
      end
    end

    if (cs_rise_c && !done_c) begin
      if (cnt_q != 3'd0) begin
        ferr_d = 1'b1;
      end
      cnt_d   = 3'd0;
      shift_d = 7'd0;
    end

    if (done_c) begin
      valid_d = 1'b1;
      word_d  = word_c;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= {SYNC_STAGES{SYNC_IDLE}};
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      shift_q     <= 7'd0;
      cnt_q       <= 3'd0;
      valid_q     <= 1'b0;
      word_q      <= '0;
      ferr_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      word_q      <= word_d;
      ferr_q      <= ferr_d;
    end
  end

  assign rx_valid  = valid_q;
  assign rx_word   = word_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/oled_panel_rx.sv
// Panel-side receiver: command decode, page/column pointer and GRAM write port.
module oled_panel_rx
  import oled_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_PAGES   = 8,
  parameter int unsigned NUM_COLS    = 128
) (
  input  logic                                         CLK,
  input  logic                                         RST,
  input  logic                                         OLED_SCLK,
  input  logic                                         OLED_CS,
  input  logic                                         OLED_DC,
  input  logic                                         OLED_DIN,
  output logic                                         RX_VALID,
  output logic [7:0]                                   RX_BYTE,
  output logic                                         RX_DC,
  output logic                                         RAM_WE,
  output logic [$clog2(NUM_PAGES)+$clog2(NUM_COLS)-1:0] RAM_ADDR,
  output logic [7:0]                                   RAM_DATA,
  output logic                                         FRAME_ERR
);

  localparam int unsigned PG_W = $clog2(NUM_PAGES);
  localparam int unsigned CL_W = $clog2(NUM_COLS);

  logic      rx_valid;
  spi_word_t rx_word;
  logic      frame_err;
  logic      done_c;
  spi_word_t word_c;

  oled_spi_deser #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_deser (
    .clk      (CLK),
    .rst      (RST),
    .sclk     (OLED_SCLK),
    .cs_n     (OLED_CS),
    .dc       (OLED_DC),
    .din      (OLED_DIN),
    .rx_valid (rx_valid),
    .rx_word  (rx_word),
    .frame_err(frame_err),
    .done_c   (done_c),
    .word_c   (word_c)
  );

  logic [PG_W-1:0] page_q, page_d;
  logic [CL_W-1:0] col_q, col_d;
  logic            we_q, we_d;
  logic [7:0]      data_q, data_d;
  logic [6:0]      col_full_c;

  assign col_full_c = 7'(col_q);

  // Pointer update one cycle after the byte is presented, so writes use the pre-increment address.
  always_comb begin
    page_d = page_q;
    col_d  = col_q;
    if (rx_valid) begin
      if (rx_word.dc) begin
        col_d = col_q + CL_W'(1);
      end else begin
        case (classify_cmd(rx_word.data))
          CMD_PAGE:   page_d = PG_W'(rx_word.data[2:0]);
          CMD_COL_LO: col_d  = CL_W'({col_full_c[6:4], rx_word.data[3:0]});
          CMD_COL_HI: col_d  = CL_W'({rx_word.data[2:0], col_full_c[3:0]});
          default:    ;
        endcase
      end
    end
  end

  // GRAM strobe registered alongside RX_VALID for data bytes.
  always_comb begin
    we_d   = done_c & word_c.dc;
    data_d = data_q;
    if (we_d) begin
      data_d = word_c.data;
    end
  end

  // Pointer and GRAM port registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      page_q <= '0;
      col_q  <= '0;
      we_q   <= 1'b0;
      data_q <= 8'd0;
    end else begin
      page_q <= page_d;
      col_q  <= col_d;
      we_q   <= we_d;
      data_q <= data_d;
    end
  end

  assign RX_VALID  = rx_valid;
  assign RX_BYTE   = rx_word.data;
  assign RX_DC     = rx_word.dc;
  assign RAM_WE    = we_q;
  assign RAM_ADDR  = {page_q, col_q};
  assign RAM_DATA  = data_q;
  assign FRAME_ERR = frame_err;

endmodule

// File: tb/tb_oled_panel_rx.sv
// Directed bench for oled_panel_rx with hand-computed expectations.
module tb_oled_panel_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       OLED_SCLK, OLED_CS, OLED_DC, OLED_DIN;
  logic       RX_VALID, RX_DC, RAM_WE, FRAME_ERR;
  logic [7:0] RX_BYTE, RAM_DATA;
  logic [9:0] RAM_ADDR;

  int checks = 0;
  int errors = 0;

  // Event monitor state
  int         n_valid = 0, n_we = 0, n_ferr = 0;
  logic [7:0] last_byte = 8'd0;
  logic       last_dc = 1'b0;
  logic [9:0] we_addr = 10'd0;
  logic [7:0] we_data = 8'd0;

  always #5 CLK = ~CLK;

  oled_panel_rx #(.SYNC_STAGES(2), .NUM_PAGES(8), .NUM_COLS(128)) dut (
    .CLK(CLK), .RST(RST),
    .OLED_SCLK(OLED_SCLK), .OLED_CS(OLED_CS), .OLED_DC(OLED_DC), .OLED_DIN(OLED_DIN),
    .RX_VALID(RX_VALID), .RX_BYTE(RX_BYTE), .RX_DC(RX_DC),
    .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_DATA(RAM_DATA),
    .FRAME_ERR(FRAME_ERR)
  );

  // Count output pulses on the falling edge, away from the active edge
  always @(negedge CLK) begin
    if (RX_VALID) begin
      n_valid   <= n_valid + 1;
      last_byte <= RX_BYTE;
      last_dc   <= RX_DC;
    end
    if (RAM_WE) begin
      n_we    <= n_we + 1;
      we_addr <= RAM_ADDR;
      we_data <= RAM_DATA;
    end
    if (FRAME_ERR) n_ferr <= n_ferr + 1;
  end

  function automatic logic [9:0] addr(input int page, input int col);
    return {3'(page), 7'(col)};
  endfunction

  task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      OLED_DIN  = b[7-i];
      OLED_DC   = dc;
      OLED_SCLK = 1'b0;
      repeat (4) @(negedge CLK);
      OLED_SCLK = 1'b1;
      repeat (4) @(negedge CLK);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, dc, 8);
    OLED_SCLK = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic cs_set(input logic v);
    OLED_CS = v;
    repeat (8) @(negedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", RX_VALID); end
    checks++; if (RX_BYTE !== 8'h00) begin errors++; $display("FAIL reset_rx_byte got %h want 00", RX_BYTE); end
    checks++; if (RX_DC !== 1'b0) begin errors++; $display("FAIL reset_rx_dc got %b want 0", RX_DC); end
    checks++; if (RAM_WE !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b want 0", RAM_WE); end
    checks++; if (RAM_ADDR !== 10'd0) begin errors++; $display("FAIL reset_ram_addr got %h want 000", RAM_ADDR); end
    checks++; if (RAM_DATA !== 8'h00) begin errors++; $display("FAIL reset_ram_data got %h want 00", RAM_DATA); end
    checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", FRAME_ERR); end
    RST = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_pointer;
    int v0, w0;
    v0 = n_valid; w0 = n_we;
    cs_set(1'b0);
    send_byte(8'hB3, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h12, 1'b0);
    checks++; if (n_valid - v0 !== 3) begin errors++; $display("FAIL ptr_cmd_valids got %0d want 3", n_valid - v0); end
    checks++; if (last_dc !== 1'b0) begin errors++; $display("FAIL ptr_cmd_dc got %b want 0", last_dc); end
    checks++; if (n_we - w0 !== 0) begin errors++; $display("FAIL ptr_cmd_no_we got %0d want 0", n_we - w0); end
    checks++; if (RAM_ADDR !== addr(3, 37)) begin errors++; $display("FAIL ptr_after_cmd got %h want %h", RAM_ADDR, addr(3, 37)); end
    send_byte(8'hA5, 1'b1);
    checks++; if (n_we - w0 !== 1) begin errors++; $display("FAIL ptr_data_we got %0d want 1", n_we - w0); end
    checks++; if (we_addr !== addr(3, 37)) begin errors++; $display("FAIL ptr_write_addr got %h want %h", we_addr, addr(3, 37)); end
    checks++; if (we_data !== 8'hA5) begin errors++; $display("FAIL ptr_write_data got %h want a5", we_data); end
    checks++; if (last_dc !== 1'b1) begin errors++; $display("FAIL ptr_data_dc got %b want 1", last_dc); end
    checks++; if (RAM_ADDR !== addr(3, 38)) begin errors++; $display("FAIL ptr_after_write got %h want %h", RAM_ADDR, addr(3, 38)); end
    cs_set(1'b1);
  endtask

  task automatic test_col_wrap;
    cs_set(1'b0);
    send_byte(8'h17, 1'b0);
    send_byte(8'h0F, 1'b0);
    checks++; if (RAM_ADDR !== addr(3, 127)) begin errors++; $display("FAIL wrap_col127 got %h want %h", RAM_ADDR, addr(3, 127)); end
    send_byte(8'h11, 1'b1);
    checks++; if (we_addr !== addr(3, 127) || we_data !== 8'h11) begin errors++; $display("FAIL wrap_first_write got %h/%h want %h/11", we_addr, we_data, addr(3, 127)); end
    send_byte(8'h22, 1'b1);
    checks++; if (we_addr !== addr(3, 0) || we_data !== 8'h22) begin errors++; $display("FAIL wrap_second_write got %h/%h want %h/22", we_addr, we_data, addr(3, 0)); end
    checks++; if (RAM_ADDR !== addr(3, 1)) begin errors++; $display("FAIL wrap_after got %h want %h", RAM_ADDR, addr(3, 1)); end
    cs_set(1'b1);
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    cs_set(1'b0);
    send_bits(8'hFF, 1'b0, 5);
    OLED_SCLK = 1'b0;
    repeat (2) @(negedge CLK);
    cs_set(1'b1);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_pulse got %0d want 1", n_ferr - f0); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL ferr_no_valid got %0d want 0", n_valid - v0); end
    cs_set(1'b0);
    send_byte(8'h3C, 1'b0);
    checks++; if (last_byte !== 8'h3C || n_valid - v0 !== 1) begin errors++; $display("FAIL ferr_next_byte got %h (%0d) want 3c (1)", last_byte, n_valid - v0); end
    cs_set(1'b1);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_clean_close got %0d want 1", n_ferr - f0); end
    checks++; if (RAM_ADDR !== addr(3, 1)) begin errors++; $display("FAIL ferr_ptr got %h want %h", RAM_ADDR, addr(3, 1)); end
  endtask

  task automatic test_cs_high;
    int v0, w0, f0;
    v0 = n_valid; w0 = n_we; f0 = n_ferr;
    send_bits(8'hFF, 1'b1, 8);
    OLED_SCLK = 1'b0;
    repeat (6) @(negedge CLK);
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL cshigh_valid got %0d want 0", n_valid - v0); end
    checks++; if (n_we - w0 !== 0) begin errors++; $display("FAIL cshigh_we got %0d want 0", n_we - w0); end
    cs_set(1'b0);
    send_byte(8'h81, 1'b0);
    checks++; if (last_byte !== 8'h81) begin errors++; $display("FAIL cshigh_counter_clean got %h want 81", last_byte); end
    cs_set(1'b1);
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL cshigh_ferr got %0d want 0", n_ferr - f0); end
  endtask

  task automatic test_unrecognised;
    int v0, w0;
    v0 = n_valid; w0 = n_we;
    cs_set(1'b0);
    send_byte(8'hAF, 1'b0);
    checks++; if (last_byte !== 8'hAF) begin errors++; $display("FAIL unrec_byte_af got %h want af", last_byte); end
    send_byte(8'h81, 1'b0);
    checks++; if (n_valid - v0 !== 2) begin errors++; $display("FAIL unrec_valids got %0d want 2", n_valid - v0); end
    checks++; if (n_we - w0 !== 0) begin errors++; $display("FAIL unrec_we got %0d want 0", n_we - w0); end
    checks++; if (RAM_ADDR !== addr(3, 1)) begin errors++; $display("FAIL unrec_ptr got %h want %h", RAM_ADDR, addr(3, 1)); end
    cs_set(1'b1);
  endtask

  task automatic test_latency;
    int lat;
    logic we_seen;
    lat = 0; we_seen = 1'b0;
    cs_set(1'b0);
    send_bits(8'h5A, 1'b1, 7);
    OLED_DIN  = 1'b0;
    OLED_SCLK = 1'b0;
    repeat (4) @(negedge CLK);
    OLED_SCLK = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (RX_VALID && lat == 0) begin
        lat = i;
        we_seen = RAM_WE;
      end
    end
    OLED_SCLK = 1'b0;
    repeat (4) @(negedge CLK);
    checks++; if (lat !== 3) begin errors++; $display("FAIL latency_cycles got %0d want 3", lat); end
    checks++; if (we_seen !== 1'b1) begin errors++; $display("FAIL latency_we_same_cycle got %b want 1", we_seen); end
    checks++; if (we_addr !== addr(3, 1) || we_data !== 8'h5A) begin errors++; $display("FAIL latency_write got %h/%h want %h/5a", we_addr, we_data, addr(3, 1)); end
    cs_set(1'b1);
  endtask

  task automatic test_same_cycle;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    cs_set(1'b0);
    send_bits(8'hB5, 1'b0, 7);
    OLED_DIN  = 1'b1;
    OLED_SCLK = 1'b0;
    repeat (4) @(negedge CLK);
    OLED_SCLK = 1'b1;
    OLED_CS   = 1'b1;
    repeat (4) @(negedge CLK);
    OLED_SCLK = 1'b0;
    repeat (8) @(negedge CLK);
    checks++; if (n_valid - v0 !== 1 || last_byte !== 8'hB5) begin errors++; $display("FAIL same_cycle_byte got %h (%0d) want b5 (1)", last_byte, n_valid - v0); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL same_cycle_ferr got %0d want 0", n_ferr - f0); end
    checks++; if (RAM_ADDR !== addr(5, 2)) begin errors++; $display("FAIL same_cycle_page got %h want %h", RAM_ADDR, addr(5, 2)); end
  endtask

  task automatic test_rst_mid;
    int v0, w0, f0;
    cs_set(1'b0);
    send_bits(8'hC3, 1'b1, 4);
    RST = 1'b1;
    #1;
    checks++; if (RX_BYTE !== 8'h00 || RX_DC !== 1'b0) begin errors++; $display("FAIL rst_mid_rx got %h/%b want 00/0", RX_BYTE, RX_DC); end
    checks++; if (RAM_ADDR !== 10'd0 || RAM_DATA !== 8'h00) begin errors++; $display("FAIL rst_mid_ram got %h/%h want 000/00", RAM_ADDR, RAM_DATA); end
    v0 = n_valid; w0 = n_we; f0 = n_ferr;
    OLED_SCLK = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    send_byte(8'h55, 1'b1);
    checks++; if (n_we - w0 !== 1 || we_addr !== addr(0, 0) || we_data !== 8'h55) begin errors++; $display("FAIL rst_mid_write got %h/%h (%0d) want 000/55 (1)", we_addr, we_data, n_we - w0); end
    checks++; if (n_valid - v0 !== 1 || n_ferr - f0 !== 0) begin errors++; $display("FAIL rst_mid_pulses got valid %0d ferr %0d want 1 0", n_valid - v0, n_ferr - f0); end
    checks++; if (RAM_ADDR !== addr(0, 1)) begin errors++; $display("FAIL rst_mid_ptr got %h want %h", RAM_ADDR, addr(0, 1)); end
    cs_set(1'b1);
  endtask

  initial begin
    RST       = 1'b1;
    OLED_SCLK = 1'b0;
    OLED_CS   = 1'b1;
    OLED_DC   = 1'b0;
    OLED_DIN  = 1'b0;
    test_reset;
    test_pointer;
    test_col_wrap;
    test_frame_err;
    test_cs_high;
    test_unrecognised;
    test_latency;
    test_same_cycle;
    test_rst_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
